// File: rtl/fetch_unit.sv
// Program counter, instruction register and status register stage for the SISC controller.
// Instruction fetches use a req/ack handshake with wait states and a bounded timeout.
module fetch_unit #(
    parameter int unsigned          PC_W     = 16,
    parameter int unsigned          IW       = 32,
    parameter logic [PC_W-1:0]      RESET_PC = '0,
    parameter int unsigned          MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic            ir_load,
    input  logic            stat_en,
    input  logic [3:0]      stat_in,
    input  logic [IW-1:0]   imem_rdata,
    input  logic            imem_ack,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    output logic [IW-1:0]   instr,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic [15:0]     imm,
    output logic [3:0]      stat,
    output logic [PC_W-1:0] pc_out,
    output logic            fetch_busy,
    output logic            fetch_err
);

    localparam int unsigned     CntW   = $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic [3:0]      stat_q, stat_d;
    logic            err_q, err_d;

    logic [PC_W-1:0] imm_abs, imm_rel;

    assign imm     = instr_q[15:0];
    assign imm_abs = PC_W'(imm);
    // Relative offsets are two's complement, sign-extended to the PC width.
    assign imm_rel = PC_W'($signed(imm));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fetch_addr_d = fetch_addr_q;
        instr_d      = instr_q;
        err_d        = err_q;
        unique case (state_q)
            StIdle: begin
                if (ir_load) begin
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                    end else begin
                        fetch_addr_d = pc_q;
                        cnt_d        = CntW'(1);
                        state_d      = StWait;
                    end
                end
            end
            StWait: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == MaxCnt) begin
                    instr_d = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (pc_rst) begin
            pc_d = RESET_PC;
        end else if (pc_write) begin
            if (!pc_sel) begin
                pc_d = pc_q + PC_W'(1);
            end else if (br_sel) begin
                pc_d = imm_abs;
            end else begin
                pc_d = pc_q + imm_rel;
            end
        end
    end

    always_comb begin
        stat_d = stat_en ? stat_in : stat_q;
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            instr_q      <= '0;
            stat_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            instr_q      <= instr_d;
            stat_q       <= stat_d;
            err_q        <= err_d;
        end
    end

    assign imem_req   = (state_q == StWait) || ir_load;
    assign imem_addr  = (state_q == StWait) ? fetch_addr_q : pc_q;
    assign fetch_busy = (state_q == StWait);
    assign instr      = instr_q;
    assign opcode     = instr_q[31:28];
    assign mm         = instr_q[27:24];
    assign stat       = stat_q;
    assign pc_out     = pc_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: completed fetches are scoreboarded against a queue of
// expected (address, data) pairs; PC, status and timeout behaviour are checked directly.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load, stat_en, imem_ack;
    logic [3:0]  stat_in;
    logic [31:0] imem_rdata;
    logic        imem_req, fetch_busy, fetch_err;
    logic [15:0] imem_addr, imm, pc_out;
    logic [31:0] instr;
    logic [3:0]  opcode, mm, stat;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } fetch_t;

    fetch_t      exp_q[$];
    logic        pend_valid = 1'b0;
    logic [31:0] pend_data;

    fetch_unit #(
        .PC_W     (16),
        .IW       (32),
        .RESET_PC (16'h0000),
        .MAX_WAIT (8)
    ) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .pc_rst     (pc_rst),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .br_sel     (br_sel),
        .ir_load    (ir_load),
        .stat_en    (stat_en),
        .stat_in    (stat_in),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .instr      (instr),
        .opcode     (opcode),
        .mm         (mm),
        .imm        (imm),
        .stat       (stat),
        .pc_out     (pc_out),
        .fetch_busy (fetch_busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted handshake pops one expected fetch; instr is checked a cycle later.
    always @(negedge clk) begin
        fetch_t e;
        if (pend_valid) begin
            check("sb_instr", instr, pend_data);
            pend_valid = 1'b0;
        end
        if (!rst_f && imem_req && imem_ack) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_addr", {16'h0, imem_addr}, {16'h0, e.addr});
                pend_data  = e.data;
                pend_valid = 1'b1;
            end
        end
    end

    // Zero-wait fetch; pcw also advances the PC in the same cycle.
    task automatic zfetch(input logic [15:0] addr, input logic [31:0] data, input logic pcw);
        exp_q.push_back('{addr: addr, data: data});
        ir_load    = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = data;
        pc_write   = pcw;
        pc_sel     = 1'b0;
        step();
        ir_load  = 1'b0;
        imem_ack = 1'b0;
        pc_write = 1'b0;
    endtask

    task automatic pc_op(input logic sel, input logic br);
        pc_write = 1'b1;
        pc_sel   = sel;
        br_sel   = br;
        step();
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        int req_cnt;

        rst_f = 1'b1; pc_rst = 1'b0; pc_write = 1'b1; pc_sel = 1'b0; br_sel = 1'b0;
        ir_load = 1'b0; stat_en = 1'b0; stat_in = 4'h0; imem_ack = 1'b0; imem_rdata = '0;
        step();
        step();
        rst_f    = 1'b0;
        pc_write = 1'b0;
        check("rst_pc", {16'h0, pc_out}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_stat", {28'h0, stat}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_err", {31'h0, fetch_err}, 32'h0);

        for (int i = 0; i < 4; i++) pc_op(1'b0, 1'b0);
        check("pc_inc4", {16'h0, pc_out}, 32'h4);

        // Zero-wait fetch alongside the normal PC increment.
        zfetch(16'h0004, 32'h8123_0000, 1'b1);
        check("zw_pc", {16'h0, pc_out}, 32'h5);
        check("zw_opcode", {28'h0, opcode}, 32'h8);
        check("zw_mm", {28'h0, mm}, 32'h1);
        check("zw_busy", {31'h0, fetch_busy}, 32'h0);

        for (int i = 0; i < 11; i++) pc_op(1'b0, 1'b0);
        check("pc_0x10", {16'h0, pc_out}, 32'h10);

        // Wait-state fetch: ack on the third WAIT cycle, PC moves on meanwhile.
        exp_q.push_back('{addr: 16'h0010, data: 32'h1000_0042});
        ir_load  = 1'b1;
        pc_write = 1'b1;
        step();
        ir_load  = 1'b0;
        pc_write = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'h1000_0042;
            end
            #1;
            if (fetch_busy) busy_cnt++;
            check("ws_addr_hold", {16'h0, imem_addr}, 32'h10);
            step();
        end
        imem_ack = 1'b0;
        check("ws_busy_cycles", busy_cnt, 32'd3);
        check("ws_pc_advanced", {16'h0, pc_out}, 32'h11);
        check("ws_busy_done", {31'h0, fetch_busy}, 32'h0);

        // Branches.
        zfetch(16'h0011, 32'h2000_0020, 1'b0);
        pc_op(1'b1, 1'b1);
        check("br_abs", {16'h0, pc_out}, 32'h20);
        zfetch(16'h0020, 32'h2000_0011, 1'b0);
        pc_op(1'b1, 1'b1);
        check("br_abs_back", {16'h0, pc_out}, 32'h11);
        zfetch(16'h0011, 32'h3000_FFFE, 1'b0);
        pc_op(1'b1, 1'b0);
        check("br_rel_neg", {16'h0, pc_out}, 32'h0F);
        zfetch(16'h000F, 32'h2000_FFFF, 1'b0);
        pc_op(1'b1, 1'b1);
        check("br_abs_ffff", {16'h0, pc_out}, 32'hFFFF);
        pc_op(1'b0, 1'b0);
        check("pc_wrap", {16'h0, pc_out}, 32'h0);

        // pc_rst beats a simultaneous absolute branch (which would give 0xFFFF).
        pc_op(1'b0, 1'b0);
        pc_rst   = 1'b1;
        pc_write = 1'b1;
        pc_sel   = 1'b1;
        br_sel   = 1'b1;
        step();
        pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
        check("pc_rst_prio", {16'h0, pc_out}, 32'h0);

        stat_en = 1'b1; stat_in = 4'hA;
        step();
        stat_en = 1'b0; stat_in = 4'h5;
        check("stat_load", {28'h0, stat}, 32'hA);
        step();
        check("stat_hold", {28'h0, stat}, 32'hA);

        // Timeout: no ack ever; request stays up 1 IDLE + MAX_WAIT WAIT cycles.
        ir_load = 1'b1;
        req_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (imem_req) req_cnt++;
            step();
            ir_load = 1'b0;
        end
        check("to_req_cycles", req_cnt, 32'd9);
        check("to_instr", instr, 32'h0);
        check("to_err", {31'h0, fetch_err}, 32'h1);
        check("to_idle", {31'h0, fetch_busy}, 32'h0);

        zfetch(16'h0000, 32'h0000_0005, 1'b0);
        step();
        check("err_sticky", {31'h0, fetch_err}, 32'h1);

        // Reset while waiting at counter 4.
        ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("rw_busy_before", {31'h0, fetch_busy}, 32'h1);
        rst_f = 1'b1;
        step();
        rst_f = 1'b0;
        #1;
        check("rw_req", {31'h0, imem_req}, 32'h0);
        check("rw_instr", instr, 32'h0);
        check("rw_err", {31'h0, fetch_err}, 32'h0);
        check("rw_busy", {31'h0, fetch_busy}, 32'h0);
        check("rw_stat", {28'h0, stat}, 32'h0);

        step();
        step();
        check("sb_drained", exp_q.size(), 32'd0);
        check("sb_no_pending", {31'h0, pend_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
